gmm_pwl_exp: RTL and testbench
==============================

GMM_PWL_EXP -- requirements
Module: gmm_pwl_exp

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 16, which is the output sample and coefficient width.
REQ-002 The block SHALL have parameter Z_WIDTH, default 40, which is the width of the square-accumulate result input.
REQ-003 The block SHALL have parameter Z_FRAC, default 16, which is the number of fractional bits of z.
REQ-004 The block SHALL have parameter SEG_BITS, default 4, which sets the segment count to 2^SEG_BITS.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port ce, input, 1 bit: global enable; when low, all state holds.
REQ-008 The block SHALL have ports z_r and z_i, input, signed Z_WIDTH: the real and imaginary square-accumulate results.
REQ-009 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): the input handshake.
REQ-010 The block SHALL have ports e_r and e_i, output, signed D_WIDTH: approximations of exp(-z), Q1.15, range [0, 2^(D_WIDTH-1)-1].
REQ-011 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): the output handshake.
REQ-012 The block SHALL have port coef_we, input, 1 bit: coefficient write strobe.
REQ-013 The block SHALL have port coef_addr, input, SEG_BITS wide: the segment index to write.
REQ-014 The block SHALL have ports coef_slope and coef_icpt, input, signed D_WIDTH: the segment slope and intercept.
REQ-015 The block SHALL have port busy, output, 1 bit: high while any pipeline stage holds valid data.

Function
REQ-016 Segment index and offset SHALL be computed per lane (r and i independently): seg = z[Z_FRAC+SEG_BITS-1:Z_FRAC]; off = z[Z_FRAC-1 -: D_WIDTH-1], unsigned Q0.15.
REQ-017 When z<0, seg and off SHALL be forced to 0 (clamp to exp(0)).
REQ-018 When z >= 2^(Z_FRAC+SEG_BITS), a zero flag SHALL be set and that lane's output SHALL be 0.
REQ-019 Each lane result SHALL be icpt[seg] + ((slope[seg] * {0,off}) >>> (D_WIDTH-1)), computed in D_WIDTH+2 bits with the arithmetic shift and no rounding.
REQ-020 The lane result SHALL saturate: values >2^(D_WIDTH-1)-1 clamp to 32767, values <0 clamp to 0.
REQ-021 Both lanes SHALL share one coefficient table of 2^SEG_BITS {slope, icpt} register pairs.
REQ-022 The pipeline SHALL have 3 stages: S1 clamp/index/register; S2 table read, multiply and register; S3 add, saturate, zero-flag and output register.
REQ-023 Latency SHALL be exactly 3 ce-high cycles from input acceptance to out_valid when not stalled.
REQ-024 A transfer SHALL occur on a clk edge where valid&&ready&&ce are all high.
REQ-025 in_ready SHALL equal ce && (!S1 valid || S1 advances).
REQ-026 Each stage SHALL advance only when its successor is empty or advancing; S3 advances on out_ready.
REQ-027 Throughput SHALL be 1 sample/cycle with out_ready held high.
REQ-028 Under stall, all stage data SHALL hold and no sample SHALL be dropped or duplicated; at most 3 samples are in flight.
REQ-029 e_r, e_i and out_valid SHALL be registered outputs; e_r and e_i SHALL be stable while out_valid && !out_ready.
REQ-030 A coefficient write (coef_we && ce) SHALL update the table at the clk edge, independent of the handshake.
REQ-031 An S2 read of the same address on the same edge as a write SHALL use the old value; the new value SHALL apply from the next cycle.
REQ-032 busy SHALL be the OR of the S1, S2 and S3 valid bits.

Reset
REQ-033 Assertion of rst (low) SHALL immediately clear all stage valids, out_valid and busy, drive e_r and e_i to 0, and zero every coefficient entry.
REQ-034 in_ready SHALL be 0 during reset.
REQ-035 In-flight samples present when reset asserts SHALL be discarded, and the first accepted input after release SHALL produce the first output.

Structure
REQ-036 A shared package gmm_pkg SHALL hold the Z_WIDTH, D_WIDTH and Z_FRAC defaults, Q1.15 constants EXP_ONE=32767 and EXP_ZERO=0, and the coef_t struct {slope, icpt}.
REQ-037 One sub-module, gmm_pwl_lane (single-lane S1-S3 datapath), SHALL be instantiated twice; control and the coefficient table SHALL be in the top level.

Verification
REQ-038 Load seg0 slope=-16384, icpt=32767; z_r=0 -> e_r=32767 exactly 3 cycles later.
REQ-039 Same table; z_r=0x8000 (off=16384) -> e_r=24575; z_r=-5 -> e_r=32767.
REQ-040 z_r=2^20 -> e_r=0 regardless of table; slope=+32767, icpt=32767, off=16384 -> e_r saturates to 32767.
REQ-041 Stream 6 samples with out_ready=0 for 5 cycles -> in_ready falls after 3 accepted; all 6 are delivered in order with no loss.
REQ-042 Write seg2 on the same edge S2 reads seg2 -> old result; the following sample uses the new coefficients; ce=0 for 4 cycles -> all outputs are frozen.
REQ-043 Assert rst with 3 samples in flight -> out_valid=0 and busy=0 immediately, the table reads zero, and the post-reset sample emerges with 3-cycle latency.

Source files
------------

// File: rtl/gmm_pkg.sv
// Shared defaults, Q1.15 constants and the coefficient record for the
// piecewise-linear exp(-z) approximation.
package gmm_pkg;
  localparam int GMM_D_WIDTH  = 16;
  localparam int GMM_Z_WIDTH  = 40;
  localparam int GMM_Z_FRAC   = 16;
  localparam int GMM_SEG_BITS = 4;

  localparam int EXP_ONE  = 32767;
  localparam int EXP_ZERO = 0;

  typedef struct packed {
    logic signed [GMM_D_WIDTH-1:0] slope;
    logic signed [GMM_D_WIDTH-1:0] icpt;
  } coef_t;
endpackage

// File: rtl/gmm_pwl_lane.sv
// One lane of the exp(-z) datapath: clamp/index (S1), multiply (S2),
// add/saturate (S3). The coefficient lookup for S2 is done by the parent.
module gmm_pwl_lane
  import gmm_pkg::*;
#(
  parameter int D_WIDTH  = GMM_D_WIDTH,
  parameter int Z_WIDTH  = GMM_Z_WIDTH,
  parameter int Z_FRAC   = GMM_Z_FRAC,
  parameter int SEG_BITS = GMM_SEG_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en1,
  input  logic                       en2,
  input  logic                       en3,
  input  logic signed [Z_WIDTH-1:0]  z,
  output logic [SEG_BITS-1:0]        seg,
  input  logic signed [D_WIDTH-1:0]  slope,
  input  logic signed [D_WIDTH-1:0]  icpt,
  output logic signed [D_WIDTH-1:0]  e
);
  localparam int OW   = D_WIDTH - 1;
  localparam int PW   = D_WIDTH + 2;
  localparam int ZTOP = Z_FRAC + SEG_BITS;
  localparam logic signed [PW-1:0] SAT_HI = PW'((2 ** (D_WIDTH - 1)) - 1);

  logic [SEG_BITS-1:0]       seg_q, seg_d;
  logic [OW-1:0]             off_q, off_d;
  logic                      zero1_q, zero1_d;
  logic signed [PW-1:0]      prod_q, prod_d;
  logic signed [D_WIDTH-1:0] icpt_q;
  logic                      zero2_q;
  logic signed [D_WIDTH-1:0] e_q, e_d;
  logic signed [2*D_WIDTH-1:0] prod;
  logic signed [PW-1:0]      sum;

  // Fraction bits below the Q0.15 offset do not contribute to the result.
  generate
    if (Z_FRAC > OW) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^z[Z_FRAC-OW-1:0];
    end
  endgenerate

  always_comb begin
    seg_d   = z[ZTOP-1:Z_FRAC];
    off_d   = z[Z_FRAC-1 -: OW];
    zero1_d = 1'b0;
    if (z[Z_WIDTH-1]) begin
      seg_d = '0;
      off_d = '0;
    end else if (|z[Z_WIDTH-2:ZTOP]) begin
      zero1_d = 1'b1;
    end
  end

  always_comb begin
    prod   = slope * $signed({1'b0, off_q});
    prod_d = PW'(prod >>> OW);
    sum    = $signed({{2{icpt_q[D_WIDTH-1]}}, icpt_q}) + prod_q;
    if (zero2_q || sum < 0) begin
      e_d = D_WIDTH'(EXP_ZERO);
    end else if (sum > SAT_HI) begin
      e_d = SAT_HI[D_WIDTH-1:0];
    end else begin
      e_d = sum[D_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q   <= '0;
      off_q   <= '0;
      zero1_q <= 1'b0;
      prod_q  <= '0;
      icpt_q  <= '0;
      zero2_q <= 1'b0;
      e_q     <= '0;
    end else begin
      if (en1) begin
        seg_q   <= seg_d;
        off_q   <= off_d;
        zero1_q <= zero1_d;
      end
      if (en2) begin
        prod_q  <= prod_d;
        icpt_q  <= icpt;
        zero2_q <= zero1_q;
      end
      if (en3) begin
        e_q <= e_d;
      end
    end
  end

  assign seg = seg_q;
  assign e   = e_q;
endmodule

// File: rtl/gmm_pwl_exp.sv
// Dual-lane piecewise-linear exp(-z) with a shared coefficient table and a
// 3-stage elastic pipeline (valid/ready with per-stage back-pressure).
module gmm_pwl_exp
  import gmm_pkg::*;
#(
  parameter int D_WIDTH  = GMM_D_WIDTH,
  parameter int Z_WIDTH  = GMM_Z_WIDTH,
  parameter int Z_FRAC   = GMM_Z_FRAC,
  parameter int SEG_BITS = GMM_SEG_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic signed [Z_WIDTH-1:0] z_r,
  input  logic signed [Z_WIDTH-1:0] z_i,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [D_WIDTH-1:0] e_r,
  output logic signed [D_WIDTH-1:0] e_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      coef_we,
  input  logic [SEG_BITS-1:0]       coef_addr,
  input  logic signed [D_WIDTH-1:0] coef_slope,
  input  logic signed [D_WIDTH-1:0] coef_icpt,
  output logic                      busy
);
  localparam int NSEG = 2 ** SEG_BITS;

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic acc1, acc2, acc3;
  logic en1, en2, en3;
  coef_t coef_q [NSEG];
  logic [SEG_BITS-1:0] seg_r, seg_i;

  // accN: stage N can take new data this edge (empty, or draining forward).
  always_comb begin
    acc3 = !v3_q || out_ready;
    acc2 = !v2_q || acc3;
    acc1 = !v1_q || acc2;
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (ce) begin
      if (acc3) v3_d = v2_q;
      if (acc2) v2_d = v1_q;
      if (acc1) v1_d = in_valid;
    end
  end

  assign en1 = ce && acc1 && in_valid;
  assign en2 = ce && acc2 && v1_q;
  assign en3 = ce && acc3 && v2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  // Same-edge read of a written entry sees the old pair: S2 samples before update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NSEG; k++) coef_q[k] <= '0;
    end else if (ce && coef_we) begin
      coef_q[coef_addr] <= '{slope: coef_slope, icpt: coef_icpt};
    end
  end

  gmm_pwl_lane #(
    .D_WIDTH(D_WIDTH), .Z_WIDTH(Z_WIDTH), .Z_FRAC(Z_FRAC), .SEG_BITS(SEG_BITS)
  ) u_lane_r (
    .clk(clk), .rst(rst), .en1(en1), .en2(en2), .en3(en3),
    .z(z_r), .seg(seg_r),
    .slope(coef_q[seg_r].slope), .icpt(coef_q[seg_r].icpt), .e(e_r)
  );

  gmm_pwl_lane #(
    .D_WIDTH(D_WIDTH), .Z_WIDTH(Z_WIDTH), .Z_FRAC(Z_FRAC), .SEG_BITS(SEG_BITS)
  ) u_lane_i (
    .clk(clk), .rst(rst), .en1(en1), .en2(en2), .en3(en3),
    .z(z_i), .seg(seg_i),
    .slope(coef_q[seg_i].slope), .icpt(coef_q[seg_i].icpt), .e(e_i)
  );

  assign in_ready  = rst && ce && acc1;
  assign out_valid = v3_q;
  assign busy      = v1_q || v2_q || v3_q;
endmodule

// File: tb/tb_gmm_pwl_exp.sv
// Scoreboard bench for gmm_pwl_exp: directed vectors push expected lane
// results; a negedge monitor pops and compares on every output transfer.
module tb_gmm_pwl_exp;
  localparam int DW = 16;
  localparam int ZW = 40;
  localparam int SB = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 ce = 1'b1;
  logic signed [ZW-1:0] z_r = '0;
  logic signed [ZW-1:0] z_i = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] e_r, e_i;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 coef_we = 1'b0;
  logic [SB-1:0]        coef_addr = '0;
  logic signed [DW-1:0] coef_slope = '0;
  logic signed [DW-1:0] coef_icpt = '0;
  logic                 busy;

  gmm_pwl_exp dut (
    .clk(clk), .rst(rst), .ce(ce), .z_r(z_r), .z_i(z_i),
    .in_valid(in_valid), .in_ready(in_ready), .e_r(e_r), .e_i(e_i),
    .out_valid(out_valid), .out_ready(out_ready), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_slope(coef_slope), .coef_icpt(coef_icpt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int er;
    int ei;
    int acc;
    bit lat;
  } exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int n_acc  = 0;
  int n_out  = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when these hold now.
  always @(negedge clk) begin
    exp_t x;
    if (rst && ce && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got e_r=%0d e_i=%0d, required no output", e_r, e_i);
      end else begin
        x = sb_q.pop_front();
        n_out++;
        $display("out %0d: e_r=%0d e_i=%0d (expect %0d %0d)", n_out, e_r, e_i, x.er, x.ei);
        chk("e_r", e_r, x.er);
        chk("e_i", e_i, x.ei);
        if (x.lat) chk("latency_cycles", cyc - x.acc + 1, 3);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input longint zr, input longint zi, input int er, input int ei, input bit lat);
    exp_t x;
    in_valid = 1'b1;
    z_r = zr[ZW-1:0];
    z_i = zi[ZW-1:0];
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        x.er = er; x.ei = ei; x.acc = cyc + 1; x.lat = lat;
        sb_q.push_back(x);
        n_acc++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required 1");
    in_valid = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int slope, input int icpt);
    coef_we = 1'b1;
    coef_addr = addr[SB-1:0];
    coef_slope = slope[DW-1:0];
    coef_icpt = icpt[DW-1:0];
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: z_r, z_i, expected e_r, e_i
  longint vz_r [6] = '{0, -5, 'h18000, 'h28000, 2, -(64'sd1 << 30)};
  longint vz_i [6] = '{'h8000, (64'sd1 << 20), 'h38000, 'h20000, (64'sd1 << 20) - 1, 'h30000};
  int     ve_r [6] = '{32767, 32767, 32767, 12288, 32766, 32767};
  int     ve_i [6] = '{24575, 0, 0, 16384, 1000, 100};

  // Stall stream: z_r = 0x2000*k, z_i = 0x2000*(5-k), all in segment 0
  int st_e [6] = '{32767, 30719, 28671, 26623, 24575, 22527};

  initial begin
    int c0;
    int a0;
    rst = 1'b0;
    ce = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_e_r", e_r, 0);
    chk("rst_e_i", e_i, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    write_coef(0, -16384, 32767);
    write_coef(1, 32767, 32767);
    write_coef(2, -8192, 16384);
    write_coef(3, -32768, 100);
    write_coef(15, -1000, 2000);

    // Back-to-back directed vectors: 3-cycle latency, one sample per cycle
    c0 = cyc;
    for (int k = 0; k < 6; k++) send(vz_r[k], vz_i[k], ve_r[k], ve_i[k], 1'b1);
    chk("throughput_cycles", cyc - c0, 6);
    wait_idle();

    // Back-pressure: out_ready low for 5 cycles while 6 samples are offered
    out_ready = 1'b0;
    a0 = n_acc;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(64'sh2000 * k, 64'sh2000 * (5 - k), st_e[k], st_e[5-k], 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("stall_accepted", n_acc - a0, 3);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_e_r_held", e_r, st_e[0]);
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // Coefficient write on the same edge S2 reads that segment
    send('h28000, 'h20000, 12288, 16384, 1'b1);
    coef_we = 1'b1;
    coef_addr = 4'd2;
    coef_slope = 16'sd0;
    coef_icpt = 16'sd1000;
    send('h28000, 'h20000, 1000, 1000, 1'b1);
    coef_we = 1'b0;
    wait_idle();

    // ce low for 4 cycles with data in the pipeline; writes are ignored too
    send(0, 'h8000, 32767, 24575, 1'b0);
    send('h18000, 'h28000, 32767, 1000, 1'b0);
    @(posedge clk);
    #1;
    ce = 1'b0;
    coef_we = 1'b1;
    coef_addr = 4'd2;
    coef_icpt = 16'sd5000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("freeze_out_valid", out_valid, 1);
      chk("freeze_e_r", e_r, 32767);
      chk("freeze_e_i", e_i, 24575);
      chk("freeze_in_ready", in_ready, 0);
      chk("freeze_busy", busy, 1);
    end
    coef_we = 1'b0;
    ce = 1'b1;
    wait_idle();

    // Reset with 3 samples in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(0, 0, 32767, 32767, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_e_r", e_r, 0);
    chk("midrst_e_i", e_i, 0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    send('h8000, 'h18000, 0, 0, 1'b1);
    wait_idle();

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
